// File: rtl/hcsr04_pkg.sv
// rtl/hcsr04_pkg.sv - State codes, default parameters and width helper for the HC-SR04 interface
package hcsr04_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      PREPARA     = 4'd1,
      TRIGGER     = 4'd2,
      ESPERA_ECHO = 4'd3,
      MEDE        = 4'd4,
      ARMAZENA    = 4'd5,
      FINAL       = 4'd6,
      PAUSA       = 4'd7
   } estado_t;

   localparam int N_CANAIS_PAD       = 4;
   localparam int LARGURA_PAD        = 12;
   localparam int TRIGGER_CICLOS_PAD = 500;
   localparam int CICLOS_POR_CM_PAD  = 2941;
   localparam int MODULO_TIMEOUT_PAD = 50_000_000;
   localparam int MODULO_PAUSA_PAD   = 3_000_000;

   // clog2 that never collapses to a zero-width vector
   function automatic int largura_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - Modulus-M counter with synchronous clear (zera), enable (conta) and terminal flag (fim)
module contador_m
   import hcsr04_pkg::*;
#(
   parameter int M = 16
)(
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_zera,
   input  logic i_conta,
   output logic o_fim
);
   localparam int W = largura_min1(M);

   logic [W-1:0] r_q;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_zera) begin
         r_q <= '0;
      end else if (i_conta) begin
         r_q <= o_fim ? '0 : r_q + 1'b1;
      end
   end

   assign o_fim = (r_q == W'(M - 1));

endmodule

// File: rtl/interface_hcsr04_multi.sv
// rtl/interface_hcsr04_multi.sv - Multi-channel HC-SR04 ultrasonic ranger: trigger, echo timing, timeout and scan
module interface_hcsr04_multi
   import hcsr04_pkg::*;
#(
   parameter int  N_CANAIS       = N_CANAIS_PAD,
   parameter int  LARGURA        = LARGURA_PAD,
   parameter int  TRIGGER_CICLOS = TRIGGER_CICLOS_PAD,
   parameter int  CICLOS_POR_CM  = CICLOS_POR_CM_PAD,
   parameter int  MODULO_TIMEOUT = MODULO_TIMEOUT_PAD,
   parameter int  MODULO_PAUSA   = MODULO_PAUSA_PAD,
   localparam int W_CANAL        = largura_min1(N_CANAIS)
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                medir,
   input  logic                modo,
   input  logic [W_CANAL-1:0]  canal_sel,
   input  logic [N_CANAIS-1:0] echo,
   output logic [N_CANAIS-1:0] trigger,
   output logic [LARGURA-1:0]  medida,
   output logic [W_CANAL-1:0]  canal,
   output logic                timeout,
   output logic                pronto,
   output logic [3:0]          db_estado
);
   localparam logic [LARGURA-1:0] MEDIDA_MAX = '1;

   estado_t             r_estado;
   logic [N_CANAIS-1:0] r_echo_s1, r_echo_s2;
   logic [N_CANAIS-1:0] r_trigger;
   logic [LARGURA-1:0]  r_medida, r_dist;
   logic [W_CANAL-1:0]  r_canal, r_canal_ativo, r_ponteiro;
   logic                r_timeout, r_pronto, r_modo, r_flag_to;

   logic                w_echo_ativo, w_zera;
   logic                w_conta_trig, w_conta_to, w_conta_cm, w_conta_pausa;
   logic                w_fim_trig, w_fim_to, w_fim_cm, w_fim_pausa;
   logic [W_CANAL-1:0]  w_canal_prox;
   logic [N_CANAIS-1:0] w_onehot;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_echo_s1 <= '0;
         r_echo_s2 <= '0;
      end else begin
         r_echo_s1 <= echo;
         r_echo_s2 <= r_echo_s1;
      end
   end

   assign w_echo_ativo  = r_echo_s2[r_canal_ativo];
   assign w_zera        = (r_estado == PREPARA);
   assign w_conta_trig  = (r_estado == TRIGGER);
   assign w_conta_to    = (r_estado == ESPERA_ECHO) || (r_estado == MEDE);
   // the cycle that detects the rising echo already belongs to the pulse width
   assign w_conta_cm    = w_conta_to && w_echo_ativo;
   assign w_conta_pausa = (r_estado == PAUSA);
   assign w_canal_prox  = r_modo ? r_ponteiro : canal_sel;

   always_comb begin
      w_onehot               = '0;
      w_onehot[w_canal_prox] = 1'b1;
   end

   contador_m #(.M(TRIGGER_CICLOS)) u_cont_trigger (
      .i_clock(clock), .i_reset(reset), .i_zera(w_zera), .i_conta(w_conta_trig),  .o_fim(w_fim_trig));
   contador_m #(.M(CICLOS_POR_CM)) u_cont_cm (
      .i_clock(clock), .i_reset(reset), .i_zera(w_zera), .i_conta(w_conta_cm),    .o_fim(w_fim_cm));
   contador_m #(.M(MODULO_TIMEOUT)) u_cont_timeout (
      .i_clock(clock), .i_reset(reset), .i_zera(w_zera), .i_conta(w_conta_to),    .o_fim(w_fim_to));
   contador_m #(.M(MODULO_PAUSA)) u_cont_pausa (
      .i_clock(clock), .i_reset(reset), .i_zera(w_zera), .i_conta(w_conta_pausa), .o_fim(w_fim_pausa));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado      <= INICIAL;
         r_trigger     <= '0;
         r_medida      <= '0;
         r_canal       <= '0;
         r_timeout     <= 1'b0;
         r_pronto      <= 1'b0;
         r_dist        <= '0;
         r_canal_ativo <= '0;
         r_ponteiro    <= '0;
         r_modo        <= 1'b0;
         r_flag_to     <= 1'b0;
      end else begin
         r_pronto <= 1'b0;
         if (w_conta_cm && w_fim_cm && (r_dist != MEDIDA_MAX)) begin
            r_dist <= r_dist + 1'b1;
         end
         case (r_estado)
            INICIAL: begin
               if (medir) begin
                  r_modo   <= modo;
                  r_estado <= PREPARA;
               end
            end
            PREPARA: begin
               r_canal_ativo <= w_canal_prox;
               r_dist        <= '0;
               r_flag_to     <= 1'b0;
               r_trigger     <= w_onehot;
               r_estado      <= TRIGGER;
            end
            TRIGGER: begin
               if (w_fim_trig) begin
                  r_trigger <= '0;
                  r_estado  <= ESPERA_ECHO;
               end
            end
            ESPERA_ECHO: begin
               if (w_fim_to) begin
                  r_flag_to <= 1'b1;
                  r_estado  <= ARMAZENA;
               end else if (w_echo_ativo) begin
                  r_estado <= MEDE;
               end
            end
            MEDE: begin
               // timeout wins over a simultaneous echo end
               if (w_fim_to) begin
                  r_flag_to <= 1'b1;
                  r_estado  <= ARMAZENA;
               end else if (!w_echo_ativo) begin
                  r_estado <= ARMAZENA;
               end
            end
            ARMAZENA: begin
               r_medida  <= r_flag_to ? MEDIDA_MAX : r_dist;
               r_canal   <= r_canal_ativo;
               r_timeout <= r_flag_to;
               r_pronto  <= 1'b1;
               r_estado  <= FINAL;
            end
            FINAL: begin
               r_estado <= PAUSA;
            end
            PAUSA: begin
               if (w_fim_pausa) begin
                  r_modo <= modo;
                  if (modo) begin
                     r_ponteiro <= (r_ponteiro == W_CANAL'(N_CANAIS - 1)) ? '0 : r_ponteiro + 1'b1;
                     r_estado   <= PREPARA;
                  end else begin
                     r_estado <= INICIAL;
                  end
               end
            end
            default: r_estado <= INICIAL;
         endcase
      end
   end

   assign trigger   = r_trigger;
   assign medida    = r_medida;
   assign canal     = r_canal;
   assign timeout   = r_timeout;
   assign pronto    = r_pronto;
   assign db_estado = r_estado;

endmodule

// File: doc/interface_hcsr04_multi.md
INTERFACE_HCSR04_MULTI -- requirements
Module: interface_hcsr04_multi

Interface
REQ-001 SHALL have parameter N_CANAIS, default 4: number of HC-SR04 sensors served, 1..8.
REQ-002 SHALL have parameter LARGURA, default 12: width of the binary distance result in cm.
REQ-003 SHALL have parameter TRIGGER_CICLOS, default 500: trigger pulse length in clocks (10 us at 50 MHz).
REQ-004 SHALL have parameter CICLOS_POR_CM, default 2941: echo-high clocks per 1 cm.
REQ-005 SHALL have parameter MODULO_TIMEOUT, default 50_000_000: clocks from trigger end to abort (1 s).
REQ-006 SHALL have parameter MODULO_PAUSA, default 3_000_000: mandatory gap between measurements in clocks (60 ms).
REQ-007 SHALL have port clock, input, 1: sole clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port medir, input, 1: start request, sampled in INICIAL only.
REQ-010 SHALL have port modo, input, 1: 0 = single measurement on canal_sel; 1 = continuous round-robin scan.
REQ-011 SHALL have port canal_sel, input, clog2(N_CANAIS) bits (min 1): channel used in single mode.
REQ-012 SHALL have port echo, input, N_CANAIS bits: asynchronous echo lines, one per sensor.
REQ-013 SHALL have port trigger, output, N_CANAIS bits: trigger lines, at most one bit high at any time.
REQ-014 SHALL have port medida, output, LARGURA bits: last registered distance.
REQ-015 SHALL have port canal, output, clog2(N_CANAIS) bits: channel that produced medida.
REQ-016 SHALL have port timeout, output, 1: last registered measurement aborted by timeout.
REQ-017 SHALL have port pronto, output, 1: one-clock pulse when medida/canal/timeout update.
REQ-018 SHALL have port db_estado, output, 4 bits: current FSM state code.

Function
REQ-019 SHALL pass each echo bit through a 2-flop synchronizer; all echo references below use the synchronized value.
REQ-020 SHALL implement states INICIAL=0, PREPARA=1, TRIGGER=2, ESPERA_ECHO=3, MEDE=4, ARMAZENA=5, FINAL=6, PAUSA=7; db_estado shows code; unused codes return to INICIAL.
REQ-021 INICIAL: on medir=1 go PREPARA; PREPARA latches the active channel (canal_sel in mode 0, scan pointer in mode 1) and zeros all counters.
REQ-022 TRIGGER: trigger[active] high for exactly TRIGGER_CICLOS clocks, then ESPERA_ECHO.
REQ-023 ESPERA_ECHO: wait for echo[active]=1 then MEDE; MEDE: count clocks, increment distance every CICLOS_POR_CM clocks, go ARMAZENA when echo[active]=0.
REQ-024 Distance SHALL saturate at 2^LARGURA-1, never wrap.
REQ-025 Timeout counter SHALL run through ESPERA_ECHO and MEDE; reaching MODULO_TIMEOUT-1 forces ARMAZENA with timeout=1 and medida=2^LARGURA-1; echo end and timeout in the same cycle SHALL resolve as timeout.
REQ-026 ARMAZENA registers medida, canal, timeout; FINAL asserts pronto for one clock; then PAUSA for MODULO_PAUSA clocks.
REQ-027 After PAUSA: if modo=1, advance scan pointer (N_CANAIS-1 wraps to 0) and go PREPARA without medir; if modo=0, go INICIAL.
REQ-028 modo change SHALL take effect only at PAUSA exit; canal_sel changes only matter in PREPARA.
REQ-029 Echo lines of non-active channels SHALL be ignored.

Reset
REQ-030 reset=1 SHALL, at the next edge and overriding all else, enter INICIAL, clear trigger, medida, canal, timeout, pronto, scan pointer and all counters, including mid-measurement.

Structure
REQ-031 State codes and default parameter values SHALL live in package hcsr04_pkg.
REQ-032 Trigger, cm, timeout and pause counters SHALL each be an instance of sub-module contador_m (modulus counter with zera, conta, fim).

Verification (N_CANAIS=2, LARGURA=8, TRIGGER_CICLOS=4, CICLOS_POR_CM=10, MODULO_TIMEOUT=300, MODULO_PAUSA=8)
REQ-033 modo=0, canal_sel=1, medir pulse, echo[1] high 57 clocks -> trigger[1] high 4 clocks, pronto once, medida=5, canal=1, timeout=0.
REQ-034 echo never rises -> pronto after timeout, medida=255, timeout=1, then INICIAL after 8-clock pause.
REQ-035 modo=1, medir once, echo widths 30/120 clocks -> pronto pairs canal 0 medida 3, canal 1 medida 12, repeating.
REQ-036 echo high 2600 clocks, MODULO_TIMEOUT raised to 5000 -> medida=255 (saturated), timeout=0.
REQ-037 reset asserted during MEDE -> next cycle db_estado=0, trigger=0, medida=0, pronto=0.
REQ-038 echo[0] toggles while channel 1 measures -> channel 1 result unchanged.
